// File: rtl/pipelined_mux_nx1.sv
// N:1 multiplexer built as a binary tree of 2:1 selects with valid/ready
// handshaking. Grant is fixed-channel or round-robin; the granted index
// travels with the data and steers each tree level. With PIPELINED=1 every
// level is registered, otherwise only the final level is.
module pipelined_mux_nx1 #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned PIPELINED  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic [$clog2(NUM_INPUTS)-1:0] sel,
  input  logic [NUM_INPUTS*WIDTH-1:0]   in_data,
  input  logic [NUM_INPUTS-1:0]         in_valid,
  output logic [NUM_INPUTS-1:0]         in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(NUM_INPUTS)-1:0] out_chan,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned SELW = $clog2(NUM_INPUTS);

  logic [SELW-1:0]  r_rr_ptr;
  logic [SELW-1:0]  w_gidx;
  logic [SELW-1:0]  w_cand;
  logic             w_gvalid;
  logic             w_stall;
  logic             w_accept;

  // Tree nodes, level by level: level l occupies entries
  // [NUM_INPUTS - (NUM_INPUTS >> l) +: NUM_INPUTS >> (l+1)]; the last entry is the root.
  logic [WIDTH-1:0] w_node [NUM_INPUTS-1];
  logic [SELW-1:0]  w_lidx [SELW];
  logic             w_lv   [SELW];

  assign w_stall  = out_valid & ~out_ready;
  assign w_accept = w_gvalid & ~w_stall & ~rst;

  // Grant: fixed channel sel, or first requester at/after rr_ptr with wrap
  always_comb begin
    w_gidx   = '0;
    w_gvalid = 1'b0;
    w_cand   = '0;
    if (!mode) begin
      w_gidx   = sel;
      w_gvalid = in_valid[sel];
    end else begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        w_cand = r_rr_ptr + SELW'(i);
        if (!w_gvalid && in_valid[w_cand]) begin
          w_gidx   = w_cand;
          w_gvalid = 1'b1;
        end
      end
    end
  end

  // One-hot accept for the granted channel only when the pipe can advance
  always_comb begin
    in_ready         = '0;
    in_ready[w_gidx] = w_accept;
  end

  // Round-robin pointer moves past the winner on each round-robin transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept && mode) begin
      r_rr_ptr <= w_gidx + SELW'(1);
    end
  end

  for (genvar l = 0; l < SELW; l++) begin : g_lvl
    localparam int unsigned NO   = NUM_INPUTS >> (l + 1);
    localparam int          OFF  = int'(NUM_INPUTS) - int'(NUM_INPUTS >> l);
    localparam int          IOFF = OFF - int'(2 * NO);

    logic [SELW-1:0] w_idx_in;
    logic            w_v_in;

    if (l == 0) begin : g_ctl_src
      assign w_idx_in = w_gidx;
      assign w_v_in   = w_accept;
    end else begin : g_ctl_src
      assign w_idx_in = w_lidx[l-1];
      assign w_v_in   = w_lv[l-1];
    end

    if (PIPELINED != 0 || l == SELW - 1) begin : g_ctl_reg
      logic [SELW-1:0] r_idx;
      logic            r_v;
      // Carried index and valid bit for this level; frozen while stalled
      always_ff @(posedge clk) begin
        if (rst) begin
          r_idx <= '0;
          r_v   <= 1'b0;
        end else if (!w_stall) begin
          r_idx <= w_idx_in;
          r_v   <= w_v_in;
        end
      end
      assign w_lidx[l] = r_idx;
      assign w_lv[l]   = r_v;
    end else begin : g_ctl_comb
      assign w_lidx[l] = w_idx_in;
      assign w_lv[l]   = w_v_in;
    end

    for (genvar j = 0; j < NO; j++) begin : g_pair
      logic [WIDTH-1:0] w_a;
      logic [WIDTH-1:0] w_b;
      logic [WIDTH-1:0] w_m;

      if (l == 0) begin : g_src
        assign w_a = in_data[(2*j)*WIDTH +: WIDTH];
        assign w_b = in_data[(2*j+1)*WIDTH +: WIDTH];
      end else begin : g_src
        assign w_a = w_node[IOFF + 2*j];
        assign w_b = w_node[IOFF + 2*j + 1];
      end

      // Bit l of the granted index picks the odd or even child
      assign w_m = w_idx_in[l] ? w_b : w_a;

      if (PIPELINED != 0 || l == SELW - 1) begin : g_reg
        logic [WIDTH-1:0] r_d;
        // Pair result register; frozen while stalled
        always_ff @(posedge clk) begin
          if (rst) begin
            r_d <= '0;
          end else if (!w_stall) begin
            r_d <= w_m;
          end
        end
        assign w_node[OFF + j] = r_d;
      end else begin : g_comb
        assign w_node[OFF + j] = w_m;
      end
    end
  end

  assign out_data  = w_node[NUM_INPUTS-2];
  assign out_chan  = w_lidx[SELW-1];
  assign out_valid = w_lv[SELW-1];

endmodule

// File: tb/tb_pipelined_mux_nx1.sv
// Bench for pipelined_mux_nx1: a pipelined (LAT=3) and a single-register
// (LAT=1) instance share stimulus; each is tracked by its own delay-line model.
module tb_pipelined_mux_nx1;

  localparam int N = 8;
  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           mode;
  logic           out_ready;
  logic [2:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;

  logic [N-1:0] rdy_p, rdy_c;
  logic [W-1:0] dat_p, dat_c;
  logic [2:0]   chn_p, chn_c;
  logic         vld_p, vld_c;

  pipelined_mux_nx1 #(.WIDTH(W), .NUM_INPUTS(N), .PIPELINED(1)) dut_p (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy_p), .out_data(dat_p), .out_chan(chn_p),
    .out_valid(vld_p), .out_ready(out_ready)
  );

  pipelined_mux_nx1 #(.WIDTH(W), .NUM_INPUTS(N), .PIPELINED(0)) dut_c (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy_c), .out_data(dat_c), .out_chan(chn_c),
    .out_valid(vld_c), .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a LAT-deep delay line of {valid, known, data, chan} per instance.
  logic         m_v [2][3];
  bit           m_k [2][3];
  logic [W-1:0] m_d [2][3];
  logic [2:0]   m_c [2][3];
  int           m_rr[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_rr[k] = 0;
      for (int s = 0; s < 3; s++) begin
        m_v[k][s] = 1'b0; m_k[k][s] = 1'b1; m_d[k][s] = '0; m_c[k][s] = '0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int           L, gi, c;
      bit           st, gv, acc;
      logic [N-1:0] er, ar;
      logic [W-1:0] ad;
      logic [2:0]   ac;
      logic         av;
      ar = (k == 0) ? rdy_p : rdy_c;
      ad = (k == 0) ? dat_p : dat_c;
      ac = (k == 0) ? chn_p : chn_c;
      av = (k == 0) ? vld_p : vld_c;
      L  = (k == 0) ? 3 : 1;
      st = m_v[k][L-1] && !out_ready;
      gv = 1'b0;
      gi = 0;
      if (!mode) begin
        gi = int'(sel);
        gv = in_valid[sel];
      end else begin
        for (int n = 0; n < N; n++) begin
          c = (m_rr[k] + n) % N;
          if (!gv && in_valid[c]) begin gv = 1'b1; gi = c; end
        end
      end
      acc = gv && !st && !rst;
      er = '0;
      if (acc) er[gi] = 1'b1;
      chk($sformatf("in_ready[dut%0d]", k), 64'(ar), 64'(er));
      chk($sformatf("out_valid[dut%0d]", k), 64'(av), 64'(m_v[k][L-1]));
      if (m_k[k][L-1]) begin
        chk($sformatf("out_data[dut%0d]", k), ad, m_d[k][L-1]);
        chk($sformatf("out_chan[dut%0d]", k), 64'(ac), 64'(m_c[k][L-1]));
      end
      if (rst) begin
        m_rr[k] = 0;
        for (int s = 0; s < 3; s++) begin
          m_v[k][s] = 1'b0; m_k[k][s] = 1'b1; m_d[k][s] = '0; m_c[k][s] = '0;
        end
      end else if (!st) begin
        for (int s = L - 1; s > 0; s--) begin
          m_v[k][s] = m_v[k][s-1]; m_k[k][s] = m_k[k][s-1];
          m_d[k][s] = m_d[k][s-1]; m_c[k][s] = m_c[k][s-1];
        end
        m_v[k][0] = acc;
        m_k[k][0] = acc;
        m_d[k][0] = acc ? in_data[gi*W +: W] : '0;
        m_c[k][0] = gi[2:0];
        if (acc && mode) m_rr[k] = (gi + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rr_seq [5];

  initial begin
    rr_seq[0] = 8'h01; rr_seq[1] = 8'h04; rr_seq[2] = 8'h20; rr_seq[3] = 8'h80; rr_seq[4] = 8'h01;
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 64'h1111_0000_0000_0000 * 64'(i) + 64'(i);

    // Reset: nothing accepted
    @(negedge clk);
    chk("reset in_ready", 64'(rdy_p), 64'h0);
    chk("reset out_valid", 64'(vld_p), 64'h0);
    step(); step();

    // Fixed select of channel 5 with all channels valid
    rst = 1'b0; mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    chk("fixed in_ready", 64'(rdy_p), 64'h20);
    chk("fixed first out_valid p", 64'(vld_p), 64'h0);
    @(negedge clk);
    chk("lat1 out_valid", 64'(vld_c), 64'h1);
    chk("lat1 out_chan", 64'(chn_c), 64'd5);
    chk("lat1 out_data", dat_c, 64'h5555_0000_0000_0005);
    chk("lat3 cyc1 out_valid", 64'(vld_p), 64'h0);
    @(negedge clk);
    chk("lat3 cyc2 out_valid", 64'(vld_p), 64'h0);
    @(negedge clk);
    chk("lat3 cyc3 out_valid", 64'(vld_p), 64'h1);
    chk("lat3 out_chan", 64'(chn_p), 64'd5);
    chk("lat3 out_data", dat_p, 64'h5555_0000_0000_0005);
    @(negedge clk);
    chk("lat3 cyc4 out_valid", 64'(vld_p), 64'h1);
    step();

    // Round robin over channels 0,2,5,7 starting from reset
    rst = 1'b1;
    step();
    rst = 1'b0; mode = 1'b1; in_valid = 8'b1010_0101;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rr grant %0d p", i), 64'(rdy_p), 64'(rr_seq[i]));
      chk($sformatf("rr grant %0d c", i), 64'(rdy_c), 64'(rr_seq[i]));
      step();
    end

    // Back-pressure for four cycles
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall in_ready p", 64'(rdy_p), 64'h0);
      chk("stall out_valid p", 64'(vld_p), 64'h1);
      step();
    end
    out_ready = 1'b1;
    repeat (6) step();

    // Fixed select of an idle channel produces bubbles
    mode = 1'b0; sel = 3'd3; in_valid = 8'hF7;
    @(negedge clk);
    chk("idle in_ready", 64'(rdy_p), 64'h0);
    step(); step(); step();
    @(negedge clk);
    chk("bubble out_valid p", 64'(vld_p), 64'h0);
    chk("bubble out_valid c", 64'(vld_c), 64'h0);
    step();

    // Reset with three words in flight
    mode = 1'b1; in_valid = 8'hFF;
    step(); step(); step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst comb in_ready", 64'(rdy_p), 64'h0);
    step();
    @(negedge clk);
    chk("flush out_valid", 64'(vld_p), 64'h0);
    chk("flush out_data", dat_p, 64'h0);
    chk("flush out_chan", 64'(chn_p), 64'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst grant p", 64'(rdy_p), 64'h01);
    chk("post-rst grant c", 64'(rdy_c), 64'h01);
    step();

    // Randomised traffic
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel = 3'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'($urandom);
      for (int ch = 0; ch < N; ch++) in_data[ch*W +: W] = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    rst = 1'b0; out_ready = 1'b1; in_valid = '0;
    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_mux_nx1.md
PIPELINED_MUX_NX1 -- requirements
Module: pipelined_mux_nx1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, data width per channel.
REQ-002 The block SHALL have parameter NUM_INPUTS, default 8, channel count: power of two, 2..64.
REQ-003 The block SHALL have parameter PIPELINED, default 1: 1 = register after every 2:1 tree level; 0 = single output register only.
REQ-004 Local constant SELW = log2(NUM_INPUTS); LAT = SELW if PIPELINED=1, else 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = fixed select, 1 = round-robin.
REQ-008 The block SHALL have port sel, input, SELW bits: channel index used in fixed mode.
REQ-009 The block SHALL have port in_data, input, NUM_INPUTS*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port in_valid, input, NUM_INPUTS bits: per-channel data valid.
REQ-011 The block SHALL have port in_ready, output, NUM_INPUTS bits: per-channel accept; at most one bit is high.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: selected word.
REQ-013 The block SHALL have port out_chan, output, SELW bits: source channel index of out_data.
REQ-014 The block SHALL have port out_valid, output, 1 bit: out_data/out_chan valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-016 Grant (combinational) in fixed mode SHALL be channel sel when in_valid[sel]=1; otherwise no grant.
REQ-017 Grant in round-robin mode SHALL be the first channel with in_valid=1, searching upward from rr_ptr with wrap from NUM_INPUTS-1 to 0; no grant if in_valid is all zero.
REQ-018 stall = out_valid AND NOT out_ready; while stall=1 every pipeline register, valid bit, and rr_ptr SHALL hold.
REQ-019 in_ready[g] = 1 only for granted channel g with stall=0; transfer occurs on in_valid[g] AND in_ready[g] at a clock edge.
REQ-020 Each accepted word SHALL appear on out_data with its index on out_chan and out_valid=1 exactly LAT cycles after acceptance, absent stalls; each stall cycle adds one cycle.
REQ-021 Non-accept cycles (no grant) SHALL inject a bubble (valid=0) that propagates; bubbles SHALL NOT produce out_valid.
REQ-022 Words SHALL leave in acceptance order; no word is dropped or duplicated; out_valid SHALL hold and out_data/out_chan SHALL remain stable until out_ready=1.
REQ-023 Tree level k SHALL select between pair results using bit k of the granted index, bit 0 at the leaf level; the index is carried alongside the data.
REQ-024 rr_ptr SHALL update to (granted index + 1) mod NUM_INPUTS on each round-robin transfer and SHALL NOT change in fixed mode.
REQ-025 Changing mode or sel SHALL affect only the grant of the current cycle; words already in flight are unaffected.
REQ-026 With out_ready held 1, throughput SHALL be one word per cycle.

Reset
REQ-027 While rst=1 at a clock edge, all valid bits SHALL be 0, out_data=0, out_chan=0, and rr_ptr=0.
REQ-028 in_ready SHALL be all zero during any cycle in which rst=1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight words; no partial word SHALL appear after reset is released.
REQ-030 The first acceptance SHALL be possible in the first cycle after rst falls.

Verification (NUM_INPUTS=8, WIDTH=64, PIPELINED=1, LAT=3)
REQ-031 Fixed mode, sel=5, in_valid=8'hFF, channel i data = 64'h1111_0000_0000_0000*i+i, out_ready=1 -> in_ready=8'h20; out_data=channel-5 word, out_chan=5, out_valid=1 from cycle 3 onward, one word per cycle.
REQ-032 Round-robin mode, in_valid=8'b1010_0101, out_ready=1 from reset -> grant and out_chan sequence 0,2,5,7,0,...
REQ-033 Accepted stream with out_ready=0 for 4 cycles -> out_valid stays 1, out_data/out_chan frozen, in_ready=0, and no loss or duplication after out_ready returns.
REQ-034 Fixed mode sel=3 with in_valid[3]=0 -> in_ready=0 and bubbles; out_valid=0 three cycles later.
REQ-035 rst=1 asserted with 3 words in flight -> next cycle out_valid=0, out_data=0, out_chan=0; in round robin after release with in_valid=8'hFF, the first grant is channel 0.
REQ-036 PIPELINED=0 rerun of REQ-031 -> latency 1 cycle, identical data sequence.
